// File: rtl/multi_channel_pulse_counter.sv
// Gated N-channel pulse counter with synchronised inputs, snapshot bank and indexed registered readout.
// Optional build macro CHCNT_TOTAL_EN adds a cross-channel total counter and the o_snap_total port.
module multi_channel_pulse_counter #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 12,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   i_impulse,
  input  logic              i_gate,
  input  logic              i_clear,
  output logic [N_CH-1:0]   o_ovf,
  output logic              o_snap_rdy,
  output logic              o_snap_lost,
  input  logic              i_rd_ack,
  input  logic [SEL_W-1:0]  i_rd_sel,
  output logic [WIDTH-1:0]  o_rd_data,
`ifdef CHCNT_TOTAL_EN
  output logic [WIDTH+SEL_W-1:0] o_snap_total,
`endif
  output logic              o_rd_ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [N_CH-1:0]  r_s1, r_s2, r_s3;
  logic             r_gate_d;
  logic [WIDTH-1:0] r_cnt  [N_CH];
  logic [WIDTH-1:0] r_bank [N_CH];
  logic [N_CH-1:0]  r_ovf, r_bank_ovf;
  logic             r_snap_rdy, r_snap_lost;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_ovf;

  logic [N_CH-1:0]  w_edge, w_cnt_en;
  logic             w_snap;

  assign w_edge   = r_s2 & ~r_s3;
  assign w_cnt_en = w_edge & {N_CH{i_gate}};
  assign w_snap   = r_gate_d & ~i_gate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_gate_d <= 1'b0;
    end else begin
      r_s1     <= i_impulse;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_gate_d <= i_gate;
    end
  end

  // Snapshot and clear both zero the live counters; the bank takes pre-clear values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]  <= '0;
        r_bank[i] <= '0;
      end
      r_ovf      <= '0;
      r_bank_ovf <= '0;
    end else begin
      if (w_snap) begin
        for (int i = 0; i < N_CH; i++) r_bank[i] <= r_cnt[i];
        r_bank_ovf <= r_ovf;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (w_snap || i_clear) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_cnt_en[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
            r_cnt[i] <= (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Handshake: o_snap_rdy is the bank's valid, i_rd_ack the consumer's done strobe. The bank is
  // held until acked; a snapshot arriving while valid and not acked overwrites it and flags loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap_rdy  <= 1'b0;
      r_snap_lost <= 1'b0;
    end else begin
      if (w_snap)        r_snap_rdy <= 1'b1;
      else if (i_rd_ack) r_snap_rdy <= 1'b0;
      if (w_snap && r_snap_rdy && !i_rd_ack) r_snap_lost <= 1'b1;
      else if (i_clear)                      r_snap_lost <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
    end else if (int'(i_rd_sel) < N_CH) begin
      r_rd_data <= r_bank[i_rd_sel];
      r_rd_ovf  <= r_bank_ovf[i_rd_sel];
    end else begin
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
    end
  end

`ifdef CHCNT_TOTAL_EN
  localparam int TW = WIDTH + SEL_W;

  function automatic logic [TW-1:0] popcount(input logic [N_CH-1:0] v);
    logic [TW-1:0] s;
    s = '0;
    for (int i = 0; i < N_CH; i++) s = s + {{(TW-1){1'b0}}, v[i]};
    return s;
  endfunction

  logic [TW-1:0] r_total, r_snap_total;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total      <= '0;
      r_snap_total <= '0;
    end else begin
      if (w_snap) r_snap_total <= r_total;
      if (w_snap || i_clear) r_total <= '0;
      else                   r_total <= r_total + popcount(w_cnt_en);
    end
  end

  assign o_snap_total = r_snap_total;
`endif

  assign o_ovf       = r_ovf;
  assign o_snap_rdy  = r_snap_rdy;
  assign o_snap_lost = r_snap_lost;
  assign o_rd_data   = r_rd_data;
  assign o_rd_ovf    = r_rd_ovf;

endmodule

// File: tb/tb_multi_channel_pulse_counter.sv
// Bench for multi_channel_pulse_counter: wrapping and saturating instances share stimulus and are
// checked every cycle against a latency/event model, plus directed literal scenarios.
module tb_multi_channel_pulse_counter;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int MAXV = 15;
  localparam int TMOD = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]  impulse;
  logic          gate, clear, rd_ack;
  logic [SW-1:0] rd_sel;

  logic [N-1:0]  ovf   [2];
  logic          rdy   [2];
  logic          lost  [2];
  logic [W-1:0]  rdd   [2];
  logic          rdo   [2];
`ifdef CHCNT_TOTAL_EN
  logic [W+SW-1:0] stot [2];
`endif

  multi_channel_pulse_counter #(.N_CH(N), .WIDTH(W), .SATURATE(0), .SEL_W(SW)) u_dut0 (
    .clk(clk), .reset(reset), .i_impulse(impulse), .i_gate(gate), .i_clear(clear),
    .o_ovf(ovf[0]), .o_snap_rdy(rdy[0]), .o_snap_lost(lost[0]), .i_rd_ack(rd_ack),
    .i_rd_sel(rd_sel), .o_rd_data(rdd[0]),
`ifdef CHCNT_TOTAL_EN
    .o_snap_total(stot[0]),
`endif
    .o_rd_ovf(rdo[0]));

  multi_channel_pulse_counter #(.N_CH(N), .WIDTH(W), .SATURATE(1), .SEL_W(SW)) u_dut1 (
    .clk(clk), .reset(reset), .i_impulse(impulse), .i_gate(gate), .i_clear(clear),
    .o_ovf(ovf[1]), .o_snap_rdy(rdy[1]), .o_snap_lost(lost[1]), .i_rd_ack(rd_ack),
    .i_rd_sel(rd_sel), .o_rd_data(rdd[1]),
`ifdef CHCNT_TOTAL_EN
    .o_snap_total(stot[1]),
`endif
    .o_rd_ovf(rdo[1]));

  // ---------------- behavioural model ----------------
  // A rising impulse driven after edge p is counted at edge p+3 if gate is high then.
  int cyc = 0;
  int due_q [N][$];
  int m_cnt [2][N];
  bit m_ovf [2][N];
  int m_bank [2][N];
  bit m_bank_ovf [2][N];
  int m_rd [2];
  bit m_rdo [2];
  bit m_rdy, m_lost, m_gate_d;
  int m_total, m_snap_total;

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[s][c] = 0; m_ovf[s][c] = 0; m_bank[s][c] = 0; m_bank_ovf[s][c] = 0;
      end
      m_rd[s] = 0; m_rdo[s] = 0;
    end
    for (int c = 0; c < N; c++) due_q[c].delete();
    m_rdy = 0; m_lost = 0; m_gate_d = 0; m_total = 0; m_snap_total = 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      bit snap;
      bit hit [N];
      int ncnt;
      cyc++;
      for (int s = 0; s < 2; s++) begin
        m_rd[s]  = (int'(rd_sel) < N) ? m_bank[s][rd_sel] : 0;
        m_rdo[s] = (int'(rd_sel) < N) ? m_bank_ovf[s][rd_sel] : 1'b0;
      end
      ncnt = 0;
      for (int c = 0; c < N; c++) begin
        hit[c] = 0;
        while (due_q[c].size() > 0 && due_q[c][0] <= cyc) begin
          if (due_q[c][0] == cyc) hit[c] = 1;
          void'(due_q[c].pop_front());
        end
        if (hit[c] && gate) ncnt++;
      end
      snap = m_gate_d && !gate;
      if (clear) m_lost = 0;
      if (snap && m_rdy && !rd_ack) m_lost = 1;
      if (snap) m_rdy = 1;
      else if (rd_ack) m_rdy = 0;
      for (int s = 0; s < 2; s++) begin
        for (int c = 0; c < N; c++) begin
          if (snap) begin
            m_bank[s][c] = m_cnt[s][c];
            m_bank_ovf[s][c] = m_ovf[s][c];
          end
          if (snap || clear) begin
            m_cnt[s][c] = 0; m_ovf[s][c] = 0;
          end else if (hit[c] && gate) begin
            if (m_cnt[s][c] + 1 > MAXV) begin
              m_ovf[s][c] = 1;
              m_cnt[s][c] = (s == 1) ? MAXV : 0;
            end else begin
              m_cnt[s][c] = m_cnt[s][c] + 1;
            end
          end
        end
      end
      if (snap) m_snap_total = m_total;
      if (snap || clear) m_total = 0;
      else m_total = (m_total + ncnt) % TMOD;
      m_gate_d = gate;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int s = 0; s < 2; s++) begin
        int exp_ovf;
        exp_ovf = 0;
        for (int c = 0; c < N; c++) if (m_ovf[s][c]) exp_ovf |= (1 << c);
        check($sformatf("ovf[%0d]", s), int'(ovf[s]), exp_ovf);
        check($sformatf("snap_rdy[%0d]", s), int'(rdy[s]), int'(m_rdy));
        check($sformatf("snap_lost[%0d]", s), int'(lost[s]), int'(m_lost));
        check($sformatf("rd_data[%0d]", s), int'(rdd[s]), m_rd[s]);
        check($sformatf("rd_ovf[%0d]", s), int'(rdo[s]), int'(m_rdo[s]));
`ifdef CHCNT_TOTAL_EN
        check($sformatf("snap_total[%0d]", s), int'(stot[s]), m_snap_total);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_imp(input logic [N-1:0] v);
    for (int c = 0; c < N; c++)
      if (v[c] && !impulse[c]) due_q[c].push_back(cyc + 3);
    impulse = v;
  endtask

  task automatic pulses(input logic [N-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      set_imp(impulse | mask);
      step();
      step();
      set_imp(impulse & ~mask);
      step();
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
  endtask

  task automatic read_bank(input string name, input int sel, input int exp0, input int exp1,
                           input int eovf0, input int eovf1);
    rd_sel = sel[SW-1:0];
    step();
    check({name, " data0"}, int'(rdd[0]), exp0);
    check({name, " data1"}, int'(rdd[1]), exp1);
    check({name, " ovf0"}, int'(rdo[0]), eovf0);
    check({name, " ovf1"}, int'(rdo[1]), eovf1);
  endtask

  task automatic close_window();
    gate = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  int imp_run [N];

  initial begin
    reset = 1'b1; impulse = '0; gate = 0; clear = 0; rd_ack = 0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset rd_data", int'(rdd[0]), 0);
    check("reset snap_rdy", int'(rdy[0]), 0);
    reset = 1'b0;
    chk_en = 1;

    // basic window: 5 on ch0, 3 on ch2
    gate = 1'b1;
    pulses(4'b0001, 5);
    pulses(4'b0100, 3);
    close_window();
    check("t1 snap_rdy", int'(rdy[0]), 1);
    read_bank("t1 ch0", 0, 5, 5, 0, 0);
    read_bank("t1 ch2", 2, 3, 3, 0, 0);
    read_bank("t1 ch1", 1, 0, 0, 0, 0);
    ack();

    // 17 pulses: wrap vs saturate
    gate = 1'b1;
    pulses(4'b0010, 17);
    check("t2 live ovf", int'(ovf[0]), 2);
    close_window();
    read_bank("t2 ch1", 1, 1, 15, 1, 1);
    check("t2 ovf cleared", int'(ovf[0]), 0);
    ack();

    // clear mid-window after 6 pulses
    gate = 1'b1;
    pulses(4'b1000, 6);
    clear = 1'b1; step(); clear = 1'b0;
    pulses(4'b1000, 2);
    close_window();
    read_bank("t4 ch3", 3, 2, 2, 0, 0);

    // second window without ack -> lost
    gate = 1'b1;
    pulses(4'b0001, 1);
    close_window();
    check("t3 snap_lost", int'(lost[0]), 1);
    read_bank("t3 ch0", 0, 1, 1, 0, 0);

    // ack coincident with third snapshot
    gate = 1'b1;
    pulses(4'b0001, 2);
    gate = 1'b0; rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("t3 rdy kept", int'(rdy[0]), 1);
    check("t3 lost kept", int'(lost[0]), 1);
    ack();

    // clear on the snapshot cycle
    gate = 1'b1;
    pulses(4'b1000, 7);
    gate = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    read_bank("t4 clr+snap", 3, 7, 7, 0, 0);
    check("t4 lost cleared", int'(lost[0]), 0);
    ack();
    gate = 1'b1;
    pulses(4'b1000, 1);
    close_window();
    read_bank("t4 restart", 3, 1, 1, 0, 0);
    ack();

    // simultaneous pulses, some with gate low
    pulses(4'b1111, 2);
    gate = 1'b1;
    pulses(4'b0111, 2);
    close_window();
    read_bank("t5 ch0", 0, 2, 2, 0, 0);
    read_bank("t5 ch3", 3, 0, 0, 0, 0);
`ifdef CHCNT_TOTAL_EN
    check("t5 snap_total", int'(stot[0]), 6);
`endif
    ack();

    // async reset mid-window
    gate = 1'b1;
    pulses(4'b0001, 9);
    pulses(4'b0010, 9);
    reset = 1'b1; impulse = '0; gate = 1'b0;
    #1;
    check("t6 ovf", int'(ovf[0]), 0);
    check("t6 rdy", int'(rdy[1]), 0);
    check("t6 rd_data", int'(rdd[0]), 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    idle(2);

    // randomized phase
    for (int c = 0; c < N; c++) imp_run[c] = 2;
    for (int t = 0; t < 3000; t++) begin
      logic [N-1:0] nv;
      nv = impulse;
      for (int c = 0; c < N; c++) begin
        imp_run[c]++;
        if (imp_run[c] >= 2 && $urandom_range(0, 2) == 0) begin
          nv[c] = ~nv[c];
          imp_run[c] = 0;
        end
      end
      set_imp(nv);
      if (gate) gate = ($urandom_range(0, 59) != 0);
      else      gate = ($urandom_range(0, 3) == 0);
      clear  = ($urandom_range(0, 40) == 0);
      rd_ack = ($urandom_range(0, 5) == 0);
      rd_sel = SW'($urandom_range(0, N - 1));
      step();
    end
    clear = 0; rd_ack = 0;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
